// File: rtl/nh_window_builder_pkg.sv
// Shared defaults and helpers for the neighborhood window builder.
// Mirrors the network parameter header so all blocks agree on sizes.
package nh_window_builder_pkg;

    localparam int DEF_PIXEL_WIDTH = 16;
    localparam int DEF_IMG_WIDTH   = 28;
    localparam int DEF_IMG_HEIGHT  = 28;
    localparam int DEF_NH_DIM      = 2;

    // Pixels per window (NEIGHBORHOOD_SIZE).
    function automatic int nh_size(input int nh_dim);
        return nh_dim * nh_dim;
    endfunction

    // Extent of an image dimension covered by whole windows.
    function automatic int tiled_extent(input int dim, input int nh_dim);
        return (dim / nh_dim) * nh_dim;
    endfunction

endpackage

// File: rtl/nh_window_builder_line_buffer.sv
// Storage for the NH_DIM-1 upper rows of a band, one write port and a
// combinational NH_DIM-column read of every stored row.
module nh_window_builder_line_buffer
    import nh_window_builder_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int NH_DIM      = DEF_NH_DIM,
    parameter int CW          = $clog2(DEF_IMG_WIDTH),
    parameter int PH          = $clog2(DEF_NH_DIM)
) (
    input  logic                                        clock,
    input  logic                                        i_wr_en,
    input  logic [PH-1:0]                               i_wr_row,
    input  logic [CW-1:0]                               i_wr_col,
    input  logic [PIXEL_WIDTH-1:0]                      i_wr_data,
    input  logic [CW-1:0]                               i_rd_col,
    output logic [(NH_DIM-1)*NH_DIM*PIXEL_WIDTH-1:0]    o_rd_rows
);

    localparam int DEPTH = (NH_DIM - 1) * IMG_WIDTH;
    localparam int IW    = $clog2(DEPTH);
    localparam int AW    = CW + 3;

    logic [PIXEL_WIDTH-1:0] r_mem [DEPTH];
    logic [IW-1:0]          w_wr_addr;

    assign w_wr_addr = IW'(int'(i_wr_row) * IMG_WIDTH + int'(i_wr_col));

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[w_wr_addr] <= i_wr_data;
        end
    end

    // Out-of-range reads only happen on cycles whose result is never used.
    for (genvar rr = 0; rr < NH_DIM - 1; rr++) begin : g_rd_row
        for (genvar cc = 0; cc < NH_DIM; cc++) begin : g_rd_col
            logic [AW-1:0] w_addr;
            assign w_addr = AW'(rr * IMG_WIDTH + cc) + AW'(i_rd_col);
            assign o_rd_rows[(rr*NH_DIM+cc)*PIXEL_WIDTH +: PIXEL_WIDTH] =
                (w_addr < AW'(DEPTH)) ? r_mem[w_addr[IW-1:0]] : '0;
        end
    end

endmodule

// File: rtl/nh_window_builder.sv
// Turns a raster pixel stream into non-overlapping NH_DIM x NH_DIM windows
// for the pooling stage, with valid/ready on both sides and latency 1.
module nh_window_builder
    import nh_window_builder_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int NH_DIM      = DEF_NH_DIM
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [PIXEL_WIDTH-1:0]                   pixel_in,
    input  logic                                     pixel_valid,
    output logic                                     pixel_ready,
    output logic [NH_DIM*NH_DIM*PIXEL_WIDTH-1:0]     nh_vector,
    output logic                                     nh_valid,
    input  logic                                     nh_ready,
    output logic                                     frame_done
);

    localparam int NS       = nh_size(NH_DIM);
    localparam int CW       = $clog2(IMG_WIDTH);
    localparam int RW       = $clog2(IMG_HEIGHT);
    localparam int PH       = $clog2(NH_DIM);
    localparam int COL_LIM  = tiled_extent(IMG_WIDTH, NH_DIM);
    localparam int ROW_LIM  = tiled_extent(IMG_HEIGHT, NH_DIM);
    localparam int ROW_BITS = NH_DIM * PIXEL_WIDTH;
    localparam int LB_W     = (NH_DIM - 1) * ROW_BITS;

    logic [CW-1:0]             r_col_cnt;
    logic [RW-1:0]             r_row_cnt;
    logic [PH-1:0]             r_col_ph;
    logic [PH-1:0]             r_row_ph;
    logic [ROW_BITS-1:0]       r_cur_row;
    logic [NS*PIXEL_WIDTH-1:0] r_nh_vector;
    logic                      r_nh_valid;
    logic                      r_frame_done;

    logic                      w_accept;
    logic                      w_last_col;
    logic                      w_last_row;
    logic                      w_band_last;
    logic                      w_col_ph_last;
    logic                      w_lb_wr;
    logic                      w_window_done;
    logic [ROW_BITS-1:0]       w_cur_next;
    logic [LB_W-1:0]           w_lb_rows;
    logic [CW-1:0]             w_rd_col;

    // Stall input while a window waits; keeps line-buffer reads and writes ordered.
    assign pixel_ready   = !r_nh_valid || nh_ready;
    assign w_accept      = pixel_valid && pixel_ready;
    assign w_last_col    = (r_col_cnt == CW'(IMG_WIDTH - 1));
    assign w_last_row    = (r_row_cnt == RW'(IMG_HEIGHT - 1));
    assign w_band_last   = (r_row_ph == PH'(NH_DIM - 1));
    assign w_col_ph_last = (r_col_ph == PH'(NH_DIM - 1));
    assign w_lb_wr       = w_accept && !w_band_last;
    assign w_window_done = w_accept && w_band_last && w_col_ph_last
                           && (int'(r_col_cnt) < COL_LIM)
                           && (int'(r_row_cnt) < ROW_LIM);
    assign w_cur_next    = {pixel_in, r_cur_row[ROW_BITS-1:PIXEL_WIDTH]};
    assign w_rd_col      = r_col_cnt - CW'(NH_DIM - 1);

    nh_window_builder_line_buffer #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .IMG_WIDTH   (IMG_WIDTH),
        .NH_DIM      (NH_DIM),
        .CW          (CW),
        .PH          (PH)
    ) u_line_buffer (
        .clock     (clock),
        .i_wr_en   (w_lb_wr),
        .i_wr_row  (r_row_ph),
        .i_wr_col  (r_col_cnt),
        .i_wr_data (pixel_in),
        .i_rd_col  (w_rd_col),
        .o_rd_rows (w_lb_rows)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
            r_col_ph  <= '0;
            r_row_ph  <= '0;
            r_cur_row <= '0;
        end else if (w_accept) begin
            if (w_band_last) begin
                r_cur_row <= w_cur_next;
            end
            if (w_last_col) begin
                r_col_cnt <= '0;
                r_col_ph  <= '0;
                if (w_last_row) begin
                    r_row_cnt <= '0;
                    r_row_ph  <= '0;
                end else begin
                    r_row_cnt <= r_row_cnt + RW'(1);
                    r_row_ph  <= w_band_last ? '0 : r_row_ph + PH'(1);
                end
            end else begin
                r_col_cnt <= r_col_cnt + CW'(1);
                r_col_ph  <= w_col_ph_last ? '0 : r_col_ph + PH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_nh_vector  <= '0;
            r_nh_valid   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_last_row && w_last_col;
            if (w_window_done) begin
                r_nh_vector <= {w_cur_next, w_lb_rows};
                r_nh_valid  <= 1'b1;
            end else if (nh_ready) begin
                r_nh_valid  <= 1'b0;
            end
        end
    end

    assign nh_vector  = r_nh_vector;
    assign nh_valid   = r_nh_valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_nh_window_builder.sv
// Directed bench for nh_window_builder: three instances (4x4/2, 5x5/2, 6x6/3)
// with a window scoreboard filled by the driver and drained on handshakes.
module tb_nh_window_builder;
    import nh_window_builder_pkg::*;

    localparam int VW = 144;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pin = '0;
    logic        pv_a = 1'b0, pv_b = 1'b0, pv_c = 1'b0;
    logic        nr_a = 1'b1, nr_b = 1'b1, nr_c = 1'b1;
    logic        pr_a, pr_b, pr_c;
    logic        nv_a, nv_b, nv_c;
    logic        fd_a, fd_b, fd_c;
    logic [63:0]  vec_a, vec_b;
    logic [143:0] vec_c;

    int n_assert = 0;
    int n_fail   = 0;
    int fd_cnt[3]  = '{0, 0, 0};
    int win_cnt[3] = '{0, 0, 0};
    logic [VW-1:0] q_a[$];
    logic [VW-1:0] q_b[$];
    logic [VW-1:0] q_c[$];

    always #5 clk = ~clk;

    nh_window_builder #(.PIXEL_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(4), .NH_DIM(2)) u_a (
        .clock(clk), .reset(rst), .pixel_in(pin), .pixel_valid(pv_a), .pixel_ready(pr_a),
        .nh_vector(vec_a), .nh_valid(nv_a), .nh_ready(nr_a), .frame_done(fd_a));
    nh_window_builder #(.PIXEL_WIDTH(16), .IMG_WIDTH(5), .IMG_HEIGHT(5), .NH_DIM(2)) u_b (
        .clock(clk), .reset(rst), .pixel_in(pin), .pixel_valid(pv_b), .pixel_ready(pr_b),
        .nh_vector(vec_b), .nh_valid(nv_b), .nh_ready(nr_b), .frame_done(fd_b));
    nh_window_builder #(.PIXEL_WIDTH(16), .IMG_WIDTH(6), .IMG_HEIGHT(6), .NH_DIM(3)) u_c (
        .clock(clk), .reset(rst), .pixel_in(pin), .pixel_valid(pv_c), .pixel_ready(pr_c),
        .nh_vector(vec_c), .nh_valid(nv_c), .nh_ready(nr_c), .frame_done(fd_c));

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            0: return pr_a;
            1: return pr_b;
            default: return pr_c;
        endcase
    endfunction

    function automatic logic [VW-1:0] vld(input int sel);
        case (sel)
            0: return VW'(nv_a);
            1: return VW'(nv_b);
            default: return VW'(nv_c);
        endcase
    endfunction

    function automatic logic [VW-1:0] fdn(input int sel);
        case (sel)
            0: return VW'(fd_a);
            1: return VW'(fd_b);
            default: return VW'(fd_c);
        endcase
    endfunction

    task automatic set_valid(input int sel, input logic v);
        case (sel)
            0: pv_a = v;
            1: pv_b = v;
            default: pv_c = v;
        endcase
    endtask

    task automatic push_exp(input int sel, input logic [VW-1:0] v);
        case (sel)
            0: q_a.push_back(v);
            1: q_b.push_back(v);
            default: q_c.push_back(v);
        endcase
    endtask

    function automatic bit completes(input int w, input int h, input int n, input int idx);
        int r, c;
        r = idx / w;
        c = idx % w;
        return (r % n == n - 1) && (c % n == n - 1) && (c < (w / n) * n) && (r < (h / n) * n);
    endfunction

    // Window ending at pixel idx, with pixel value = base + raster index.
    function automatic logic [VW-1:0] model_win(input int w, input int n, input int idx, input int base);
        logic [VW-1:0] v;
        int r, c;
        v = '0;
        r = idx / w;
        c = idx % w;
        for (int rr = 0; rr < n; rr++)
            for (int cc = 0; cc < n; cc++)
                v[(rr*n+cc)*16 +: 16] = 16'(base + (r - n + 1 + rr) * w + (c - n + 1 + cc));
        return v;
    endfunction

    task automatic send(input int sel, input int w, input int h, input int n,
                        input int idx, input int base);
        bit acc;
        int budget;
        acc = 0;
        budget = 0;
        pin = 16'(base + idx);
        set_valid(sel, 1'b1);
        while (!acc && budget < 200) begin
            @(negedge clk);
            if (rdy(sel)) acc = 1;
            @(posedge clk);
            budget++;
        end
        if (acc && completes(w, h, n, idx)) push_exp(sel, model_win(w, n, idx, base));
        #1;
        set_valid(sel, 1'b0);
        check($sformatf("accept_%0d_px%0d", sel, idx), VW'(acc), VW'(1));
        check($sformatf("nh_valid_%0d_px%0d", sel, idx), vld(sel), VW'(completes(w, h, n, idx)));
        check($sformatf("frame_done_%0d_px%0d", sel, idx), fdn(sel), VW'(idx == w * h - 1));
    endtask

    task automatic frame(input int sel, input int w, input int h, input int n,
                         input int base, input bit sparse, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (sparse) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send(sel, w, h, n, i, base);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (nv_a && nr_a) begin
            win_cnt[0]++;
            check("a_window_expected", VW'(q_a.size() != 0), VW'(1));
            if (q_a.size() != 0) check("a_window", VW'(vec_a), q_a.pop_front());
        end
        if (nv_b && nr_b) begin
            win_cnt[1]++;
            check("b_window_expected", VW'(q_b.size() != 0), VW'(1));
            if (q_b.size() != 0) check("b_window", VW'(vec_b), q_b.pop_front());
        end
        if (nv_c && nr_c) begin
            win_cnt[2]++;
            check("c_window_expected", VW'(q_c.size() != 0), VW'(1));
            if (q_c.size() != 0) check("c_window", vec_c, q_c.pop_front());
        end
        if (fd_a) fd_cnt[0]++;
        if (fd_b) fd_cnt[1]++;
        if (fd_c) fd_cnt[2]++;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset_nh_valid_%0d", s), vld(s), '0);
            check($sformatf("reset_frame_done_%0d", s), fdn(s), '0);
            check($sformatf("reset_pixel_ready_%0d", s), VW'(rdy(s)), VW'(1));
        end
        check("reset_vec_a", VW'(vec_a), '0);
        check("reset_vec_b", VW'(vec_b), '0);
        check("reset_vec_c", vec_c, '0);

        // Full 4x4 frame, continuous.
        frame(0, 4, 4, 2, 0, 0, 16);
        idle(4);

        // Backpressure: hold the first window for 5 cycles.
        fork
            frame(0, 4, 4, 2, 200, 0, 16);
            begin
                int i;
                i = 0;
                while (nv_a !== 1'b1 && i < 100) begin
                    @(posedge clk);
                    #1;
                    i++;
                end
                nr_a = 1'b0;
                check("bp_window_seen", VW'(nv_a), VW'(1));
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold_vector", VW'(vec_a), model_win(4, 2, 5, 200));
                    check("bp_hold_valid", VW'(nv_a), VW'(1));
                    check("bp_pixel_ready_low", VW'(pr_a), '0);
                    @(posedge clk);
                    #1;
                end
                nr_a = 1'b1;
            end
        join
        idle(4);

        // Sparse input on 4x4.
        frame(0, 4, 4, 2, 400, 1, 16);
        idle(4);

        // Reset mid-frame with a window pending, then a fresh frame.
        nr_a = 1'b0;
        frame(0, 4, 4, 2, 600, 0, 6);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q_a.delete();
        nr_a = 1'b1;
        check("midreset_nh_valid", VW'(nv_a), '0);
        check("midreset_vector", VW'(vec_a), '0);
        check("midreset_frame_done", VW'(fd_a), '0);
        frame(0, 4, 4, 2, 800, 0, 16);
        idle(4);

        // Non-divisible 5x5.
        frame(1, 5, 5, 2, 0, 0, 25);
        idle(4);

        // NH_DIM=3 on 6x6, two frames back to back.
        frame(2, 6, 6, 3, 0, 0, 36);
        frame(2, 6, 6, 3, 1000, 0, 36);
        idle(6);

        check("a_scoreboard_empty", VW'(q_a.size()), '0);
        check("b_scoreboard_empty", VW'(q_b.size()), '0);
        check("c_scoreboard_empty", VW'(q_c.size()), '0);
        check("a_window_count", VW'(win_cnt[0]), VW'(16));
        check("b_window_count", VW'(win_cnt[1]), VW'(4));
        check("c_window_count", VW'(win_cnt[2]), VW'(8));
        check("a_frame_done_count", VW'(fd_cnt[0]), VW'(4));
        check("b_frame_done_count", VW'(fd_cnt[1]), VW'(1));
        check("c_frame_done_count", VW'(fd_cnt[2]), VW'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
